// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer:
// controller state encoding, Booth operation codes and the pair decoder.
package booth_pkg;

  // Controller states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operation applied to the accumulator in one Booth iteration
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_e;

  // Decode the Booth pair {Q[0], Q-1}: 01 -> add M, 10 -> subtract M,
  // 00/11 -> leave the accumulator alone.
  function automatic op_e booth_decode(input logic q0, input logic qm1);
    op_e op;
    case ({q0, qm1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit adder with operand invert and carry-in.
// Subtraction is a + ~b + 1; the carry-out is deliberately not produced
// because the accumulator is one bit wider than the operands and cannot
// overflow.
module booth_addsub #(
  parameter int W = 11
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] b_eff;

  // Invert the second operand and inject Cin=1 when subtracting
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    sum_o = a_i + b_eff + {{(W-1){1'b0}}, sub_i};
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for a radix-2 signed Booth multiplier.
// Owns the A/Q/Q-1 registers, the iteration counter and the
// start/busy/done handshake; one add/sub per clock over WIDTH iterations.
// Optional build macro: BOOTH_ZERO_SKIP_EN -- when defined, a start with a
// zero operand bypasses the iterations and goes straight to DONE.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int AW    = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [AW-1:0]        m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 done_q, done_d;

  op_e                  op;
  logic [AW-1:0]        add_sum;
  logic [AW-1:0]        acc;

  // Booth pair decode and accumulator update for the current iteration
  always_comb begin
    op  = booth_decode(q_q[0], qm1_q);
    acc = (op == OP_NONE) ? a_q : add_sum;
  end

  booth_addsub #(
    .W (AW)
  ) u_addsub (
    .a_i   (a_q),
    .b_i   (m_q),
    .sub_i (op == OP_SUB),
    .sum_o (add_sum)
  );

  // State and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in CALC, publish in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_CALC;
`ifdef BOOTH_ZERO_SKIP_EN
          // Zero operand: clear Q too so {A,Q} is already the zero product
          if ((multiplicand == '0) || (multiplier == '0)) begin
            q_d     = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end

      ST_CALC: begin
        // Arithmetic shift right of {acc, Q, Q-1}, acc MSB replicated
        a_d   = {acc[AW-1], acc[AW-1:1]};
        q_d   = {acc[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Lower 2*WIDTH bits of {A,Q}; the extra A guard bit is dropped
        prod_d  = {a_q[WIDTH-1:0], q_q};
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == ST_CALC);
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl (WIDTH=10).
// Honours BOOTH_ZERO_SKIP_EN for the zero-operand timing expectations.
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  mcand = '0;
  logic [9:0]  mplier = '0;
  logic        busy;
  logic        done;
  logic [19:0] product;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZERO_EDGES = 1;
  localparam int ZERO_BUSY  = 0;
`else
  localparam int ZERO_EDGES = 11;
  localparam int ZERO_BUSY  = 10;
`endif

  always #5 clk = ~clk;

  booth_seq_ctrl #(.WIDTH(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One multiply: start for one cycle, scramble operands after accept,
  // optionally pulse a competing start at sample index poke_k.
  // k counts clock edges after the accept edge; done is expected at k==exp_edges.
  task automatic run_mul(input string name, input logic [9:0] m, input logic [9:0] q,
                         input logic [19:0] exp_p, input int exp_edges,
                         input int exp_busy, input int poke_k);
    int k;
    int busy_n;
    bit seen;
    bit held_ok;
    logic [19:0] prev_p;
    prev_p  = product;
    busy_n  = 0;
    seen    = 1'b0;
    held_ok = 1'b1;
    @(negedge clk);
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = 10'($urandom);
    mplier = 10'($urandom);
    for (k = 0; k <= 40; k++) begin
      if (k == poke_k) begin
        start = 1'b1; mcand = 10'd9; mplier = 10'd9;
      end else if (k == poke_k + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (product !== prev_p) held_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(k), 32'(exp_edges));
    check({name, " product"}, 32'(product), 32'(exp_p));
    check({name, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({name, " product_held"}, 32'(held_ok), 32'd1);
    @(posedge clk);
    #1;
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    $display("mul %s: product=%0h latency=%0d busy_cycles=%0d", name, product, k, busy_n);
  endtask

  initial begin
    int k;
    int last;
    int ndone;

    // Reset state
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_mul("7x-3", 10'd7, 10'h3FD, 20'hFFFEB, 11, 10, -1);
    run_mul("-512x-512", 10'h200, 10'h200, 20'h40000, 11, 10, -1);
    run_mul("0x123", 10'd0, 10'd123, 20'h00000, ZERO_EDGES, ZERO_BUSY, -1);
    run_mul("-1x-1", 10'h3FF, 10'h3FF, 20'h00001, 11, 10, -1);

    // Competing start at cycle 4 is ignored; result then holds while idle
    run_mul("5x5_poke", 10'd5, 10'd5, 20'd25, 11, 10, 3);
    repeat (5) @(posedge clk);
    #1;
    check("idle product_hold", 32'(product), 32'd25);
    check("idle busy", 32'(busy), 32'd0);

    // Start held high: back-to-back multiplies every 12 cycles
    @(negedge clk);
    mcand = 10'd255; mplier = 10'd2; start = 1'b1;
    @(posedge clk);
    #1;
    k = 0; last = 0; ndone = 0;
    while (ndone < 3 && k < 100) begin
      if (done) begin
        if (ndone == 0) check("b2b first_latency", 32'(k), 32'd11);
        else check("b2b interval", 32'(k - last), 32'd12);
        check("b2b product", 32'(product), 32'd510);
        $display("b2b pulse %0d at edge %0d product=%0d", ndone, k, product);
        last = k;
        ndone++;
      end
      if (ndone < 3) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    start = 1'b0;
    check("b2b pulses", 32'(ndone), 32'd3);
    repeat (3) @(posedge clk);

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    mcand = 10'd100; mplier = 10'h39C; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort no_done", 32'(done), 32'd0);
    $display("abort: busy=%0d done=%0d product=%0h", busy, done, product);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul("3x4", 10'd3, 10'd4, 20'd12, 11, 10, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Sequencing controller for a radix-2 signed Booth multiplier.
- Reuses one (WIDTH+1)-bit add/sub datapath once per clock, iterating over WIDTH multiplier bits.
- Sits between a requester (start/operands) and the shared adder.
- Owns the A/Q/Q-1 registers, the iteration counter and the start/busy/done handshake.

Parameters:
WIDTH, 10, operand width in bits (two's complement). The adder is WIDTH+1 bits. The product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WIDTH  signed M, captured on accepted start
multiplier  input  WIDTH  signed Q, captured on accepted start
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse; product valid from this cycle
product  output  2*WIDTH  signed result, held until the next accepted start

Behaviour:
Reset and clock:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, product=0, A=0, Q=0, Q-1=0, M=0, count=0.
- Reset asserted mid-operation aborts immediately. No done pulse is issued and product returns to 0.

States IDLE, CALC, DONE.
IDLE:
- start=1 accepts the request.
- Load M = sign-extend(multiplicand) to WIDTH+1, Q = multiplier, A = 0, Q-1 = 0, count = 0.
- Next state is CALC and busy=1 from the following cycle.
CALC, one iteration per cycle:
- Booth pair {Q[0],Q-1} selects the operation: 00/11 none; 01 A=A+M; 10 A=A-M.
- Subtraction is implemented as A + ~M with Cin=1. The adder carry-out is ignored.
- Then arithmetic shift right of {A,Q,Q-1} by 1, with A MSB replicated.
- count increments each cycle. After iteration WIDTH (count==WIDTH-1 in that cycle), go to DONE.
DONE, lasting one cycle:
- product = lower 2*WIDTH bits of {A,Q}. done=1, busy=0.
- Next state is IDLE.

Latency:
- Start accepted at edge t.
- done is high in the cycle after edge t+WIDTH+1, i.e. WIDTH+2 cycles start-to-done (12 for WIDTH=10).

Handshake and boundary conditions:
- start while busy or in DONE is ignored; it is not queued.
- start held high continuously re-triggers on each return to IDLE, giving a back-to-back multiply every WIDTH+2 cycles.
- Operands are only sampled at accept. Changes during CALC have no effect.
- The WIDTH+1 accumulator guarantees no overflow for M = -2^(WIDTH-1). -512 x -512 = +262144 is exact in 20 bits.
- product is stable outside DONE-load. It changes only when done rises.

Optional Feature:
BOOTH_ZERO_SKIP_EN
- Defined: in IDLE, an accepted start with multiplicand==0 or multiplier==0 goes directly to DONE. product=0, done is high 2 cycles after accept, and busy is never asserted.
- Undefined: zero operands take the full WIDTH iterations. Result is identical, timing is uniform.

Decomposition:
- Shared package booth_pkg holds:
  - state encoding constants ST_IDLE, ST_CALC, ST_DONE (2-bit);
  - Booth op codes OP_NONE, OP_ADD, OP_SUB;
  - the helper that decodes {Q[0],Q-1} to an op.
- One natural sub-module: booth_addsub, a (WIDTH+1)-bit adder with Cin and operand invert. It is instantiated once and is purely combinational.
- All sequencing stays in booth_seq_ctrl.

Test Plan:
- multiplicand=7, multiplier=-3, start 1 cycle -> busy for 10 cycles; done at cycle 12; product=20'hFFFEB (-21).
- multiplicand=-512, multiplier=-512 -> product=20'h40000 (+262144); no overflow.
- multiplicand=0, multiplier=123 -> product=0. With BOOTH_ZERO_SKIP_EN: done 2 cycles after accept, busy never high. Without it: done at cycle 12.
- First start with 5×5; pulse start again at cycle 4 with 9×9 -> second start ignored; product=25; product stays 25 until a new start is accepted in IDLE.
- Start 100×-100, deassert rst_n at cycle 6 -> busy=0, product=0, no done pulse. Release rst_n, start 3×4 -> product=12 after 12 cycles.
- start held high with 255 × 2 -> done pulses every 12 cycles, product=510 each time.
